// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit and the control decoder's MDop field.
package mdu_ctrl_pkg;

    // MDop encodings; values 7-15 decode as no operation
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    // Busy counter width; holds the longest latency
    localparam int unsigned CNT_W = 4;

    function automatic logic is_start(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: produces HI/LO results for one operation.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] dsr_s;
    logic        [31:0] dsr_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               b_zero;
    logic               s_ovf;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    assign b_zero = (B == 32'd0);
    assign s_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Divisor of 1 keeps the divider defined for /0 and gives the MIPS overflow
    // result (quotient = dividend, remainder 0) for 0x80000000 / -1.
    assign dsr_s = (b_zero || s_ovf) ? 32'd1 : B;
    assign dsr_u = b_zero ? 32'd1 : B;

    assign quo_s = $signed(A) / $signed(dsr_s);
    assign rem_s = $signed(A) % $signed(dsr_s);
    assign quo_u = A / dsr_u;
    assign rem_u = A % dsr_u;

    // Select the result pair for the requested operation
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
                div0   = b_zero;
            end
            MD_DIVU: begin
                res_hi = rem_u;
                res_lo = quo_u;
                div0   = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: sequences fixed-latency ops, owns HI/LO, raises D-stage stall.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_MDuse,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      thi_q, thi_d;
    logic [31:0]      tlo_q, tlo_d;
    logic [31:0]      hi_d, lo_d;

    md_op_t      op;
    logic        start;
    logic [31:0] res_hi, res_lo;
    logic        div0;

    assign op    = md_op_t'(E_MDop);
    assign start = is_start(op);

    mdu_arith u_arith (
        .op     (op),
        .A      (E_A),
        .B      (E_B),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    // Next-state: accept ops in IDLE, count down in RUN and commit on the last cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thi_d   = thi_q;
        tlo_d   = tlo_q;
        hi_d    = HI;
        lo_d    = LO;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Divide by zero holds the current HI/LO so the commit is a no-op
                    thi_d   = div0 ? HI : res_hi;
                    tlo_d   = div0 ? LO : res_lo;
                    cnt_d   = ((op == MD_DIV) || (op == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                                  : CNT_W'(MULT_CYCLES);
                    state_d = S_RUN;
                end else if (op == MD_MTHI) begin
                    hi_d = E_A;
                end else if (op == MD_MTLO) begin
                    lo_d = E_A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = thi_q;
                    lo_d    = tlo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, hold and HI/LO registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            thi_q   <= 32'd0;
            tlo_q   <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thi_q   <= thi_d;
            tlo_q   <= tlo_d;
            HI      <= hi_d;
            LO      <= lo_d;
        end
    end

    assign Busy  = (state_q == S_RUN);
    // Start term covers the issue cycle before Busy rises
    assign Stall = D_MDuse & (start | Busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_mdu_ctrl;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    localparam int K_HI    = 0;
    localparam int K_LO    = 1;
    localparam int K_BUSY  = 2;
    localparam int K_STALL = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } probe_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } commit_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_MDuse;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Stall;

    probe_t  probes[$];
    commit_t commits[$];
    int      vecs = 0;
    int      errs = 0;
    bit      done = 1'b0;
    bit      prev_busy = 1'b0;
    int      blen = 0;

    // Reference HI/LO as the architecture defines them
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDop  (E_MDop),
        .E_A     (E_A),
        .E_B     (E_B),
        .D_MDuse (D_MDuse),
        .HI      (HI),
        .LO      (LO),
        .Busy    (Busy),
        .Stall   (Stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Architectural result of one start op, computed with 64-bit integer arithmetic
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        longint      sa, sb, p, q, r;
        logic [63:0] pu;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin
                p    = sa * sb;
                qv   = p;
                hi_m = qv[63:32];
                lo_m = qv[31:0];
            end
            4'd2: begin
                pu   = {32'd0, a} * {32'd0, b};
                hi_m = pu[63:32];
                lo_m = pu[31:0];
            end
            4'd3: if (b != 0) begin
                q    = sa / sb;
                r    = sa % sb;
                qv   = q;
                rv   = r;
                lo_m = qv[31:0];
                hi_m = rv[31:0];
            end
            4'd4: if (b != 0) begin
                lo_m = a / b;
                hi_m = a % b;
            end
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int kind, input logic [31:0] exp, input string name);
        probe_t p;
        p.kind = kind;
        p.exp  = exp;
        p.name = name;
        probes.push_back(p);
    endtask

    task automatic push_commit(input logic [31:0] hi, input logic [31:0] lo, input int len);
        commit_t c;
        c.hi  = hi;
        c.lo  = lo;
        c.len = len;
        commits.push_back(c);
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDop = op;
        E_A    = a;
        E_B    = b;
        ref_op(op, a, b);
        push_commit(hi_m, lo_m, (op >= 4'd3) ? int'(DIV_N) : int'(MULT_N));
        probe(K_STALL, {31'd0, D_MDuse}, "stall_issue");
        tick();
        E_MDop = 4'd0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && Busy; i++) tick();
        probe(K_BUSY, 32'd0, "idle_after_op");
    endtask

    task automatic mt_op(input logic [3:0] op, input logic [31:0] a);
        E_MDop = op;
        E_A    = a;
        probe(K_STALL, 32'd0, "stall_mt");
        tick();
        E_MDop = 4'd0;
        if (op == 4'd5) begin
            hi_m = a;
            probe(K_HI, hi_m, "mthi");
        end else begin
            lo_m = a;
            probe(K_LO, lo_m, "mtlo");
        end
    endtask

    // Stimulus
    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        reset   = 1'b0;
        E_MDop  = 4'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
        D_MDuse = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        probe(K_BUSY, 32'd0, "reset_busy");
        probe(K_STALL, 32'd0, "reset_stall");
        probe(K_HI, 32'd0, "reset_hi");
        probe(K_LO, 32'd0, "reset_lo");

        start_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        start_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        start_op(4'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle();

        // Stall window behind a multu with an mflo waiting in D
        D_MDuse = 1'b1;
        start_op(4'd2, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 1; i <= int'(MULT_N); i++) begin
            probe(K_STALL, 32'd1, "stall_busy");
            tick();
        end
        probe(K_STALL, 32'd0, "stall_release");
        probe(K_LO, lo_m, "lo_at_release");
        probe(K_HI, hi_m, "hi_at_release");
        D_MDuse = 1'b0;
        wait_idle();

        // Divide by zero keeps prior HI/LO
        mt_op(4'd5, 32'h1234);
        mt_op(4'd6, 32'h5678);
        start_op(4'd3, 32'h0000_0042, 32'd0);
        wait_idle();
        probe(K_HI, 32'h1234, "div0_hi");
        probe(K_LO, 32'h5678, "div0_lo");

        // Ops arriving during RUN are ignored
        start_op(4'd1, 32'h0000_0100, 32'h0000_0007);
        E_MDop = 4'd6;
        E_A    = 32'hAAAA;
        tick();
        E_MDop = 4'd3;
        E_A    = 32'h5555;
        E_B    = 32'd1;
        tick();
        E_MDop = 4'd0;
        wait_idle();
        probe(K_LO, 32'h0000_0700, "ignored_mtlo_lo");

        // Signed overflow
        start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        probe(K_LO, 32'h8000_0000, "ovf_lo");
        probe(K_HI, 32'd0, "ovf_hi");

        // Reset in the 3rd busy cycle of a div
        D_MDuse = 1'b1;
        E_MDop  = 4'd3;
        E_A     = 32'd1000;
        E_B     = 32'd7;
        tick();
        E_MDop = 4'd0;
        push_commit(32'd0, 32'd0, 3);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        probe(K_BUSY, 32'd0, "rst_mid_busy");
        probe(K_STALL, 32'd0, "rst_mid_stall");
        probe(K_HI, 32'd0, "rst_mid_hi");
        probe(K_LO, 32'd0, "rst_mid_lo");
        D_MDuse = 1'b0;
        repeat (12) tick();
        probe(K_HI, 32'd0, "no_late_hi");
        probe(K_LO, 32'd0, "no_late_lo");

        // Random back-to-back traffic
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            D_MDuse = 1'($urandom_range(0, 1));
            if (op >= 4'd5) begin
                mt_op(op, a);
            end else begin
                start_op(op, a, b);
                wait_idle();
            end
            probe(K_HI, hi_m, "rand_hi");
            probe(K_LO, lo_m, "rand_lo");
        end
        tick();
        done = 1'b1;
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: drain probes, score each completed busy window, finish when stimulus is done
    always @(negedge clk) begin
        probe_t  p;
        commit_t c;
        while (probes.size() > 0) begin
            p = probes.pop_front();
            case (p.kind)
                K_HI:    chk(p.name, HI, p.exp);
                K_LO:    chk(p.name, LO, p.exp);
                K_BUSY:  chk(p.name, {31'd0, Busy}, p.exp);
                default: chk(p.name, {31'd0, Stall}, p.exp);
            endcase
        end
        if (Busy === 1'b1) begin
            blen = blen + 1;
        end else if (prev_busy) begin
            if (commits.size() == 0) begin
                chk("unexpected_commit", 32'(blen), 32'd0);
            end else begin
                c = commits.pop_front();
                chk("commit_busy_len", 32'(blen), 32'(c.len));
                chk("commit_hi", HI, c.hi);
                chk("commit_lo", LO, c.lo);
            end
            blen = 0;
        end
        prev_busy = (Busy === 1'b1);
        if (done) begin
            chk("pending_commits", 32'(commits.size()), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
            $finish;
        end
    end

endmodule
